rfg_axis_port_arbiter: RTL

- Shares one register-file protocol engine (AXIS byte slave in, AXIS byte master out) between NUM_PORTS I/O interfaces, for example UART, SPI and Ethernet bridges.
- Grants one port at a time, round-robin, and holds the grant for exactly one complete command frame: header, address, two length bytes and any write payload.
- Tags forwarded bytes with tid = port index. Routes engine readback to the originating port by the engine's tdest.

---
 rtl/rfg_arb_pkg.sv | 17 +
 rtl/rfg_rr_select.sv | 31 +++
 rtl/rfg_axis_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rfg_arb_pkg.sv
// Shared types and header-bit positions for the register-file port arbiter.
// Imported by the arbiter top and by anything that decodes its frame state.
package rfg_arb_pkg;

  typedef enum logic [2:0] {
    ARB,
    HDR,
    ADDR,
    LENA,
    LENB,
    PAYLOAD
  } arb_state_t;

  localparam int HDR_WRITE_BIT = 0;
  localparam int HDR_READ_BIT  = 1;

endpackage

// File: rtl/rfg_rr_select.sv
// Combinational round-robin picker: returns the first requester after last_grant,
// wrapping modulo NUM_PORTS. Kept generic so other shared resources can reuse it.
module rfg_rr_select #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [2:0]           last_grant,
  output logic                 any,
  output logic [2:0]           index
);

  int key;
  int best;

  // key is the distance after last_grant; the smallest key among requesters wins
  always_comb begin
    any   = 1'b0;
    index = '0;
    key   = 0;
    best  = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      key = (i + NUM_PORTS - int'(last_grant) - 1) % NUM_PORTS;
      if (request[i] && key < best) begin
        best  = key;
        any   = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/rfg_axis_port_arbiter.sv
// Shares one register-file protocol engine between NUM_PORTS byte streams, holding
// each round-robin grant for one whole command frame and demuxing readback by tdest.
module rfg_axis_port_arbiter
  import rfg_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            port_enable,
  output logic [DATA_WIDTH-1:0]           eng_s_axis_tdata,
  output logic                            eng_s_axis_tvalid,
  input  logic                            eng_s_axis_tready,
  output logic [ID_WIDTH-1:0]             eng_s_axis_tid,
  input  logic [DATA_WIDTH-1:0]           eng_m_axis_tdata,
  input  logic                            eng_m_axis_tvalid,
  input  logic                            eng_m_axis_tlast,
  input  logic [7:0]                      eng_m_axis_tdest,
  output logic                            eng_m_axis_tready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_PORTS-1:0]            m_axis_tvalid,
  output logic [NUM_PORTS-1:0]            m_axis_tlast,
  input  logic [NUM_PORTS-1:0]            m_axis_tready,
  output logic                            grant_valid,
  output logic [2:0]                      grant_index,
  output logic [15:0]                     frame_count
);

  arb_state_t state;
  logic [2:0]  last_grant;
  logic        hdr_write;
  logic [7:0]  len_lo;
  logic [15:0] pay_cnt;
  logic        rr_any;
  logic [2:0]  rr_index;
  logic        xfer;
  logic        frame_done;

  rfg_rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
    .request    (s_axis_tvalid & port_enable),
    .last_grant (last_grant),
    .any        (rr_any),
    .index      (rr_index)
  );

  // Zero-latency forward path from the granted port; nothing passes while arbitrating
  always_comb begin
    eng_s_axis_tdata  = '0;
    eng_s_axis_tvalid = 1'b0;
    s_axis_tready     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state != ARB && grant_index == 3'(i)) begin
        eng_s_axis_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        eng_s_axis_tvalid = s_axis_tvalid[i];
        s_axis_tready[i]  = eng_s_axis_tready;
      end
    end
  end

  assign eng_s_axis_tid = ID_WIDTH'(grant_index);
  assign xfer           = eng_s_axis_tvalid && eng_s_axis_tready;

  assign frame_done = xfer && (
      (state == HDR && !eng_s_axis_tdata[HDR_WRITE_BIT] && !eng_s_axis_tdata[HDR_READ_BIT]) ||
      (state == LENB && !hdr_write) ||
      (state == PAYLOAD && pay_cnt == 16'd1));

  // Frame tracker; the frame_done override at the bottom returns every frame end to ARB
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ARB;
      grant_index <= '0;
      last_grant  <= 3'(NUM_PORTS - 1);
      grant_valid <= 1'b0;
      frame_count <= '0;
      hdr_write   <= 1'b0;
      len_lo      <= '0;
      pay_cnt     <= '0;
    end else begin
      case (state)
        ARB: begin
          if (rr_any) begin
            grant_index <= rr_index;
            last_grant  <= rr_index;
            grant_valid <= 1'b1;
            state       <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            hdr_write <= eng_s_axis_tdata[HDR_WRITE_BIT];
            state     <= ADDR;
          end
        end
        ADDR: if (xfer) state <= LENA;
        LENA: begin
          if (xfer) begin
            len_lo <= eng_s_axis_tdata[7:0];
            state  <= LENB;
          end
        end
        LENB: begin
          if (xfer) begin
            pay_cnt <= {eng_s_axis_tdata[7:0], len_lo};
            state   <= PAYLOAD;
          end
        end
        PAYLOAD: if (xfer) pay_cnt <= pay_cnt - 16'd1;
        default: state <= ARB;
      endcase
      if (frame_done) begin
        state       <= ARB;
        grant_valid <= 1'b0;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Readback demux by tdest; unknown destinations are accepted and dropped
  always_comb begin
    m_axis_tdata      = '0;
    m_axis_tvalid     = '0;
    m_axis_tlast      = '0;
    eng_m_axis_tready = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = eng_m_axis_tdata;
      if (eng_m_axis_tdest == 8'(i)) begin
        m_axis_tvalid[i]  = eng_m_axis_tvalid;
        m_axis_tlast[i]   = eng_m_axis_tlast;
        eng_m_axis_tready = m_axis_tready[i];
      end
    end
  end

endmodule
